attn_row_sched: RTL
===================

ATTN_ROW_SCHED -- requirements
Module: attn_row_sched

Interface
REQ-001 SHALL have parameter DW, default 8, operand/weight width (Q0.7 operands, UQ0.8 weights).
REQ-002 SHALL have parameter N_FEAT, default 4, features per vector.
REQ-003 SHALL have parameter N_KEY, default 4, key rows per query.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_vld  in  1  load-stream byte valid.
- s_rdy  out  1  load-stream ready.
- s_data  in  DW  load-stream byte (Q0.7).
- op_vld  out  1  operand pair valid to MAC engine.
- op_rdy  in  1  MAC engine ready.
- op_a  out  DW  query feature.
- op_b  out  DW  key feature.
- op_last_feat  out  1  last feature of current key.
- op_last_key  out  1  last pair of the row.
- w_vld  in  1  softmax weight valid.
- w_rdy  out  1  softmax weight ready.
- w_data  in  DW  weight (UQ0.8).
- m_vld  out  1  result weight valid.
- m_rdy  in  1  result consumer ready.
- m_data  out  DW  result weight.
- keep_q  in  1  reuse stored query for next row.
- busy  out  1  high in any state other than LOAD_Q with zero count.
- row_done  out  1  one-cycle pulse after final m transfer.
- rows_cnt  out  8  completed-row count, wraps 255->0.

Function
REQ-005 SHALL transfer on any channel only in a cycle where vld and rdy are both high.
REQ-006 SHALL implement FSM LOAD_Q -> LOAD_K -> ISSUE -> COLLECT -> EMIT -> (LOAD_Q, or LOAD_K if keep_q sampled high in the cycle of the last m transfer).
REQ-007 SHALL hold s_rdy high only in LOAD_Q and LOAD_K; LOAD_Q stores N_FEAT bytes to q[0..N_FEAT-1] in arrival order, LOAD_K stores N_KEY*N_FEAT bytes key-major to k[j][i].
REQ-008 SHALL leave LOAD_Q/LOAD_K in the cycle after the last byte transfer; no bubble cycles required on s between LOAD_Q and LOAD_K.
REQ-009 SHALL in ISSUE present pairs key-major: j=0..N_KEY-1 outer, i=0..N_FEAT-1 inner, op_a=q[i], op_b=k[j][i], op_vld asserted the first ISSUE cycle.
REQ-010 SHALL assert op_last_feat when i==N_FEAT-1, op_last_key when additionally j==N_KEY-1.
REQ-011 SHALL hold op_vld, op_a, op_b, flags stable while op_vld&&!op_rdy; op_vld SHALL not drop before transfer.
REQ-012 SHALL sustain one pair per cycle while op_rdy stays high (N_KEY*N_FEAT cycles minimum for ISSUE).
REQ-013 SHALL enter COLLECT after the op_last_key transfer; w_rdy high only in COLLECT; N_KEY weights stored in arrival order.
REQ-014 SHALL ignore w_vld outside COLLECT and s_vld outside LOAD states (no storage, no state change).
REQ-015 SHALL in EMIT output the stored weights in index order on m_data with m_vld high, stable under backpressure.
REQ-016 SHALL, on the final m transfer, pulse row_done the next cycle and increment rows_cnt (modulo 256).
REQ-017 SHALL, when keep_q is high at the final m transfer, skip LOAD_Q and keep q[] unchanged.
REQ-018 SHALL keep all counters sized ceil(log2) of their limit, wrapping to zero at each phase end.

Reset
REQ-019 SHALL on rst_n low at a clock edge enter LOAD_Q with all counters zero, including mid-ISSUE or mid-EMIT.
REQ-020 SHALL reset s_rdy=0, op_vld=0, w_rdy=0, m_vld=0, op_last_feat=0, op_last_key=0, row_done=0, busy=0, rows_cnt=0; s_rdy rises the first cycle after reset release.
REQ-021 SHALL not require q/k/weight storage to be reset; op_a/op_b/m_data are don't-care while their valid is low.

Structure
REQ-022 SHALL place the state enum (LOAD_Q, LOAD_K, ISSUE, COLLECT, EMIT) and default DW/N_FEAT/N_KEY constants in shared package attn_pkg.
REQ-023 SHALL place the q/k operand register file with key-major write and (j,i) read in one sub-module attn_opbuf; FSM and counters remain in attn_row_sched.

Verification
REQ-024 Load q={0x40,0x20,0x10,0x08}, k rows all 0x7F, op_rdy=1 -> 16 pairs on consecutive cycles, op_a repeats 40,20,10,08, op_last_feat on pairs 3,7,11,15, op_last_key on pair 15 only.
REQ-025 op_rdy toggled 1/0 each cycle during ISSUE -> 16 transfers in 32 cycles, outputs stable in stalled cycles, order unchanged.
REQ-026 Weights 0x10,0x30,0x50,0x70 on w with m_rdy held low 5 cycles -> m_data 10,30,50,70 in order, row_done one pulse, rows_cnt=1.
REQ-027 keep_q=1 at final m transfer, then 16 new k bytes -> no LOAD_Q phase, op_a sequence identical to previous row.
REQ-028 rst_n low for one cycle at pair 7 of ISSUE -> op_vld=0 next cycle, s_rdy=1 the cycle after reset release, rows_cnt=0, fresh row completes correctly.
REQ-029 256 back-to-back rows -> rows_cnt wraps to 0, row_done pulses 256 times.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types and default sizing for the attention row scheduler.
package attn_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned N_FEAT_DEF = 4;
  localparam int unsigned N_KEY_DEF  = 4;

  typedef enum logic [2:0] {
    LOAD_Q,
    LOAD_K,
    ISSUE,
    COLLECT,
    EMIT
  } state_e;

  // Counter width for a phase with 'limit' steps; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/attn_opbuf.sv
// Query/key operand register file: feature-indexed query, key-major key rows,
// combinational (key, feature) read port.
module attn_opbuf
  import attn_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned N_FEAT = N_FEAT_DEF,
  parameter int unsigned N_KEY  = N_KEY_DEF,
  parameter int unsigned FW     = cnt_w(N_FEAT),
  parameter int unsigned KW     = cnt_w(N_KEY)
) (
  input  logic          clk,
  input  logic          q_we,
  input  logic          k_we,
  input  logic [KW-1:0] wr_key,
  input  logic [FW-1:0] wr_feat,
  input  logic [DW-1:0] wr_data,
  input  logic [KW-1:0] rd_key,
  input  logic [FW-1:0] rd_feat,
  output logic [DW-1:0] rd_q,
  output logic [DW-1:0] rd_k
);

  logic [DW-1:0] q_mem [N_FEAT];
  logic [DW-1:0] k_mem [N_KEY][N_FEAT];

  // Operand storage is not reset; contents are only read after being loaded.
  always_ff @(posedge clk) begin
    if (q_we) q_mem[wr_feat] <= wr_data;
    if (k_we) k_mem[wr_key][wr_feat] <= wr_data;
  end

  assign rd_q = q_mem[rd_feat];
  assign rd_k = k_mem[rd_key][rd_feat];

endmodule

// File: rtl/attn_row_sched.sv
// Attention row scheduler: loads a query and key rows, streams (q, k) pairs to
// a MAC engine, collects softmax weights and re-emits them in index order.
module attn_row_sched
  import attn_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned N_FEAT = N_FEAT_DEF,
  parameter int unsigned N_KEY  = N_KEY_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_vld,
  output logic          s_rdy,
  input  logic [DW-1:0] s_data,
  output logic          op_vld,
  input  logic          op_rdy,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic          op_last_feat,
  output logic          op_last_key,
  input  logic          w_vld,
  output logic          w_rdy,
  input  logic [DW-1:0] w_data,
  output logic          m_vld,
  input  logic          m_rdy,
  output logic [DW-1:0] m_data,
  input  logic          keep_q,
  output logic          busy,
  output logic          row_done,
  output logic [7:0]    rows_cnt
);

  localparam int unsigned FW = cnt_w(N_FEAT);
  localparam int unsigned KW = cnt_w(N_KEY);

  state_e        state_q, state_d;
  logic [FW-1:0] feat_q, feat_d;
  logic [KW-1:0] key_q, key_d;
  logic          active_q;
  logic          row_done_q;
  logic [7:0]    rows_q;
  logic          q_we, k_we, w_we, done_set;
  logic [DW-1:0] w_mem [N_KEY];

  logic          last_feat, last_key;
  logic [FW-1:0] feat_inc;
  logic [KW-1:0] key_inc;

  assign last_feat = (feat_q == FW'(N_FEAT - 1));
  assign last_key  = (key_q == KW'(N_KEY - 1));
  assign feat_inc  = last_feat ? '0 : feat_q + FW'(1);
  assign key_inc   = last_key ? '0 : key_q + KW'(1);

  attn_opbuf #(
    .DW     (DW),
    .N_FEAT (N_FEAT),
    .N_KEY  (N_KEY),
    .FW     (FW),
    .KW     (KW)
  ) u_opbuf (
    .clk     (clk),
    .q_we    (q_we),
    .k_we    (k_we),
    .wr_key  (key_q),
    .wr_feat (feat_q),
    .wr_data (s_data),
    .rd_key  (key_q),
    .rd_feat (feat_q),
    .rd_q    (op_a),
    .rd_k    (op_b)
  );

  // Next-state, counter stepping and handshake outputs.
  always_comb begin
    state_d      = state_q;
    feat_d       = feat_q;
    key_d        = key_q;
    s_rdy        = 1'b0;
    op_vld       = 1'b0;
    w_rdy        = 1'b0;
    m_vld        = 1'b0;
    op_last_feat = 1'b0;
    op_last_key  = 1'b0;
    q_we         = 1'b0;
    k_we         = 1'b0;
    w_we         = 1'b0;
    done_set     = 1'b0;
    case (state_q)
      LOAD_Q: begin
        // active_q keeps s_rdy low during reset and rises one cycle after release.
        s_rdy = active_q;
        if (s_vld && active_q) begin
          q_we   = 1'b1;
          feat_d = feat_inc;
          if (last_feat) state_d = LOAD_K;
        end
      end
      LOAD_K: begin
        s_rdy = active_q;
        if (s_vld && active_q) begin
          k_we   = 1'b1;
          feat_d = feat_inc;
          if (last_feat) key_d = key_inc;
          if (last_feat && last_key) state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_vld       = 1'b1;
        op_last_feat = last_feat;
        op_last_key  = last_feat && last_key;
        if (op_rdy) begin
          feat_d = feat_inc;
          if (last_feat) key_d = key_inc;
          if (last_feat && last_key) state_d = COLLECT;
        end
      end
      COLLECT: begin
        w_rdy = 1'b1;
        if (w_vld) begin
          w_we  = 1'b1;
          key_d = key_inc;
          if (last_key) state_d = EMIT;
        end
      end
      EMIT: begin
        m_vld = 1'b1;
        if (m_rdy) begin
          key_d = key_inc;
          if (last_key) begin
            done_set = 1'b1;
            state_d  = keep_q ? LOAD_K : LOAD_Q;
          end
        end
      end
      default: state_d = LOAD_Q;
    endcase
  end

  // State, counters and row bookkeeping; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD_Q;
      feat_q     <= '0;
      key_q      <= '0;
      active_q   <= 1'b0;
      row_done_q <= 1'b0;
      rows_q     <= '0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      key_q      <= key_d;
      active_q   <= 1'b1;
      row_done_q <= done_set;
      rows_q     <= rows_q + 8'(done_set);
    end
  end

  // Weight storage, written in arrival order during COLLECT.
  always_ff @(posedge clk) begin
    if (w_we) w_mem[key_q] <= w_data;
  end

  assign m_data   = w_mem[key_q];
  assign busy     = !((state_q == LOAD_Q) && (feat_q == '0));
  assign row_done = row_done_q;
  assign rows_cnt = rows_q;

endmodule
